// File: rtl/weapon_pkg.sv
// Constants and types shared by the weapon locator, its bbox helper and the sprite ROM.
package weapon_pkg;

    localparam int W_SIZE       = 36;
    localparam int W_AMOUNT     = 3;
    localparam int H_VIS        = 640;
    localparam int V_VIS        = 480;
    localparam int BLINK_FRAMES = 64;
    localparam int TYPE_W       = 4;
    localparam int COORD_W      = 10;
    localparam int BLINK_W      = 7;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } wep_state_e;

    function automatic logic type_valid(input logic [TYPE_W-1:0] t);
        return (t < TYPE_W'(W_AMOUNT));
    endfunction

endpackage

// File: rtl/weapon_bbox_hit.sv
// Combinational sprite bounding-box test with on-screen clipping and local offsets.
// 11-bit arithmetic so a sprite near the right/bottom edge never wraps.
module weapon_bbox_hit
    import weapon_pkg::*;
#(
    parameter int SIZE = W_SIZE,
    parameter int HMAX = H_VIS,
    parameter int VMAX = V_VIS
) (
    input  logic [COORD_W-1:0] hc_i,
    input  logic [COORD_W-1:0] vc_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    output logic               hit_o,
    output logic [COORD_W-1:0] off_h_o,
    output logic [COORD_W-1:0] off_v_o
);

    logic [COORD_W:0] h_s, v_s, x_s, y_s, x_end_s, y_end_s, dh_s, dv_s;
    logic             on_screen_s, in_box_s;

    assign h_s     = {1'b0, hc_i};
    assign v_s     = {1'b0, vc_i};
    assign x_s     = {1'b0, x_i};
    assign y_s     = {1'b0, y_i};
    assign x_end_s = x_s + (COORD_W+1)'(SIZE);
    assign y_end_s = y_s + (COORD_W+1)'(SIZE);
    assign dh_s    = h_s - x_s;
    assign dv_s    = v_s - y_s;

    // Bounds compare and offsets, offsets forced to zero outside the box.
    always_comb begin
        on_screen_s = (h_s < (COORD_W+1)'(HMAX)) && (v_s < (COORD_W+1)'(VMAX));
        in_box_s    = (h_s >= x_s) && (h_s < x_end_s) && (v_s >= y_s) && (v_s < y_end_s);
        hit_o       = on_screen_s && in_box_s;
        off_h_o     = {COORD_W{1'b0}};
        off_v_o     = {COORD_W{1'b0}};
        if (hit_o) begin
            off_h_o = dh_s[COORD_W-1:0];
            off_v_o = dv_s[COORD_W-1:0];
        end else begin
            off_h_o = {COORD_W{1'b0}};
            off_v_o = {COORD_W{1'b0}};
        end
    end

endmodule

// File: rtl/weapon_locator.sv
// Weapon placement shadowing and per-pixel sprite hit generation feeding the sprite ROM.
// Optional spawn blink enabled by defining WEP_BLINK_EN.
module weapon_locator
    import weapon_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic [COORD_W-1:0] hc,
    input  logic [COORD_W-1:0] vc,
    input  logic               frame_start,
    input  logic               wep_req,
    input  logic [COORD_W-1:0] wep_x,
    input  logic [COORD_W-1:0] wep_y,
    input  logic [TYPE_W-1:0]  wep_type_in,
    input  logic               wep_clear,
    output logic               wep_ack,
    output logic               wep_err,
    output logic               is_wep_img_in_pixel,
    output logic [TYPE_W-1:0]  wep_type,
    output logic [COORD_W-1:0] wep_hc,
    output logic [COORD_W-1:0] wep_vc,
    output logic               wep_pix_en
);

    wep_state_e         state_q, state_d;
    logic               pending_q, pending_d, clear_pend_q, clear_pend_d;
    logic [COORD_W-1:0] stg_x_q, stg_x_d, stg_y_q, stg_y_d;
    logic [TYPE_W-1:0]  stg_type_q, stg_type_d;
    logic [COORD_W-1:0] sh_x_q, sh_x_d, sh_y_q, sh_y_d;
    logic [TYPE_W-1:0]  sh_type_q, sh_type_d;
    logic               ack_q, ack_d, err_q, err_d;
    logic               flag_q, flag_d, pix_en_q;
    logic [COORD_W-1:0] off_h_q, off_h_d, off_v_q, off_v_d;
    logic [TYPE_W-1:0]  type_q, type_d;
    logic               clear_eff_s, box_hit_s, blink_hide_s, hit_s;
    logic [COORD_W-1:0] box_off_h_s, box_off_v_s;

    assign clear_eff_s = clear_pend_q | wep_clear;

    // Request capture, frame-boundary commit/clear and state transitions.
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        clear_pend_d = clear_pend_q;
        stg_x_d      = stg_x_q;
        stg_y_d      = stg_y_q;
        stg_type_d   = stg_type_q;
        sh_x_d       = sh_x_q;
        sh_y_d       = sh_y_q;
        sh_type_d    = sh_type_q;
        ack_d        = 1'b0;
        err_d        = 1'b0;
        if (frame_start) begin
            clear_pend_d = 1'b0;
            if (clear_eff_s) begin
                state_d   = ST_IDLE;
                pending_d = 1'b0;
            end else if (pending_q) begin
                pending_d = 1'b0;
                ack_d     = 1'b1;
                if (type_valid(stg_type_q)) begin
                    sh_x_d    = stg_x_q;
                    sh_y_d    = stg_y_q;
                    sh_type_d = stg_type_q;
                    state_d   = ST_ACTIVE;
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                pending_d = pending_q;
            end
        end else begin
            clear_pend_d = clear_pend_q | wep_clear;
        end
        // ack_q blocks re-capture while the requester is still reacting to the ack
        if (wep_req && !pending_q && !ack_q) begin
            stg_x_d    = wep_x;
            stg_y_d    = wep_y;
            stg_type_d = wep_type_in;
            pending_d  = 1'b1;
        end else begin
            stg_x_d = stg_x_d;
        end
    end

`ifdef WEP_BLINK_EN
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic               commit_ok_s;

    assign commit_ok_s  = frame_start && !clear_eff_s && pending_q && type_valid(stg_type_q);
    assign blink_hide_s = (blink_q != {BLINK_W{1'b0}}) && blink_q[3];

    // Spawn-blink frame counter: reload on valid commit, count down per frame.
    always_comb begin
        blink_d = blink_q;
        if (commit_ok_s) begin
            blink_d = BLINK_W'(BLINK_FRAMES);
        end else if (frame_start && (blink_q != {BLINK_W{1'b0}})) begin
            blink_d = blink_q - {{(BLINK_W-1){1'b0}}, 1'b1};
        end else begin
            blink_d = blink_q;
        end
    end

    // Blink counter register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            blink_q <= {BLINK_W{1'b0}};
        end else begin
            blink_q <= blink_d;
        end
    end
`else
    assign blink_hide_s = 1'b0;
`endif

    weapon_bbox_hit u_bbox (
        .hc_i    (hc),
        .vc_i    (vc),
        .x_i     (sh_x_q),
        .y_i     (sh_y_q),
        .hit_o   (box_hit_s),
        .off_h_o (box_off_h_s),
        .off_v_o (box_off_v_s)
    );

    assign hit_s = (state_q == ST_ACTIVE) && box_hit_s && !blink_hide_s;

    // Next values of the ROM-facing pixel stage.
    always_comb begin
        flag_d  = hit_s;
        off_h_d = {COORD_W{1'b0}};
        off_v_d = {COORD_W{1'b0}};
        type_d  = {TYPE_W{1'b0}};
        if (hit_s) begin
            off_h_d = box_off_h_s;
            off_v_d = box_off_v_s;
        end else begin
            off_h_d = {COORD_W{1'b0}};
            off_v_d = {COORD_W{1'b0}};
        end
        if (state_q == ST_ACTIVE) begin
            type_d = sh_type_q;
        end else begin
            type_d = {TYPE_W{1'b0}};
        end
    end

    // State, staging/shadow and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            pending_q    <= 1'b0;
            clear_pend_q <= 1'b0;
            stg_x_q      <= {COORD_W{1'b0}};
            stg_y_q      <= {COORD_W{1'b0}};
            stg_type_q   <= {TYPE_W{1'b0}};
            sh_x_q       <= {COORD_W{1'b0}};
            sh_y_q       <= {COORD_W{1'b0}};
            sh_type_q    <= {TYPE_W{1'b0}};
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            flag_q       <= 1'b0;
            off_h_q      <= {COORD_W{1'b0}};
            off_v_q      <= {COORD_W{1'b0}};
            type_q       <= {TYPE_W{1'b0}};
            pix_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            clear_pend_q <= clear_pend_d;
            stg_x_q      <= stg_x_d;
            stg_y_q      <= stg_y_d;
            stg_type_q   <= stg_type_d;
            sh_x_q       <= sh_x_d;
            sh_y_q       <= sh_y_d;
            sh_type_q    <= sh_type_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            flag_q       <= flag_d;
            off_h_q      <= off_h_d;
            off_v_q      <= off_v_d;
            type_q       <= type_d;
            pix_en_q     <= flag_q;
        end
    end

    assign wep_ack             = ack_q;
    assign wep_err             = err_q;
    assign is_wep_img_in_pixel = flag_q;
    assign wep_type            = type_q;
    assign wep_hc              = off_h_q;
    assign wep_vc              = off_v_q;
    assign wep_pix_en          = pix_en_q;

endmodule

// File: tb/tb_weapon_locator.sv
// Scoreboard bench for weapon_locator: directed placement, reject, clear, clip and reset cases.
module tb_weapon_locator;

    logic       CLK = 1'b0;
    logic       RST;
    logic [9:0] hc, vc, wep_x, wep_y, wep_hc, wep_vc;
    logic       frame_start, wep_req, wep_clear;
    logic [3:0] wep_type_in, wep_type;
    logic       wep_ack, wep_err, is_wep_img_in_pixel, wep_pix_en;

    weapon_locator dut (
        .CLK(CLK), .RST(RST), .hc(hc), .vc(vc), .frame_start(frame_start),
        .wep_req(wep_req), .wep_x(wep_x), .wep_y(wep_y), .wep_type_in(wep_type_in),
        .wep_clear(wep_clear), .wep_ack(wep_ack), .wep_err(wep_err),
        .is_wep_img_in_pixel(is_wep_img_in_pixel), .wep_type(wep_type),
        .wep_hc(wep_hc), .wep_vc(wep_vc), .wep_pix_en(wep_pix_en)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         cyc;
        logic       flag;
        logic [9:0] oh;
        logic [9:0] ov;
        logic [3:0] typ;
        logic       pix;
        logic       ack;
        logic       err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    logic       r_req = 1'b0, r_clr = 1'b0;
    int         r_x = 0, r_y = 0, r_t = 0;
    logic       exp_active = 1'b0;
    int         exp_x = 0, exp_y = 0, exp_type = 0;
    logic       prev_flag = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: pops the expectation for the stimulus registered on the last edge.
    always @(negedge CLK) begin
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            mon_e = sb.pop_front();
            n_tests++;
            if (mon_e.cyc != cyc - 1 || is_wep_img_in_pixel !== mon_e.flag ||
                wep_hc !== mon_e.oh || wep_vc !== mon_e.ov || wep_type !== mon_e.typ ||
                wep_pix_en !== mon_e.pix || wep_ack !== mon_e.ack || wep_err !== mon_e.err) begin
                n_fail++;
                $display("FAIL pixel hc=%0d vc=%0d: got flag=%b off=%0d,%0d type=%0d pix_en=%b ack=%b err=%b; need flag=%b off=%0d,%0d type=%0d pix_en=%b ack=%b err=%b (tag %0d now %0d)",
                         hc, vc, is_wep_img_in_pixel, wep_hc, wep_vc, wep_type, wep_pix_en, wep_ack, wep_err,
                         mon_e.flag, mon_e.oh, mon_e.ov, mon_e.typ, mon_e.pix, mon_e.ack, mon_e.err, mon_e.cyc, cyc);
            end
        end
    end

    task automatic step(input int h, input int v, input logic fs, input logic eack, input logic eerr);
        exp_t e;
        @(posedge CLK);
        #1;
        hc          = h[9:0];
        vc          = v[9:0];
        frame_start = fs;
        wep_req     = r_req;
        wep_x       = r_x[9:0];
        wep_y       = r_y[9:0];
        wep_type_in = r_t[3:0];
        wep_clear   = r_clr;
        r_clr       = 1'b0;
        e.flag = exp_active && (h < 640) && (v < 480) && (h >= exp_x) && (h < exp_x + 36) &&
                 (v >= exp_y) && (v < exp_y + 36);
        e.oh   = e.flag ? 10'(h - exp_x) : 10'd0;
        e.ov   = e.flag ? 10'(v - exp_y) : 10'd0;
        e.typ  = exp_active ? exp_type[3:0] : 4'd0;
        e.pix  = prev_flag;
        prev_flag = e.flag;
        e.ack  = eack;
        e.err  = eerr;
        e.cyc  = cyc;
        sb.push_back(e);
    endtask

    task automatic scan(input int h0, input int h1, input int v0, input int v1, input int hs, input int vs);
        for (int v = v0; v <= v1; v += vs)
            for (int h = h0; h <= h1; h += hs)
                step(h, v, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic fs_step(input logic eack, input logic eerr);
        step(700, 480, 1'b1, eack, eerr);
    endtask

    task automatic drain();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #1;
    endtask

    task automatic check_zero(input string name);
        n_tests++;
        if ({wep_ack, wep_err, is_wep_img_in_pixel, wep_type, wep_hc, wep_vc, wep_pix_en} !== 28'd0) begin
            n_fail++;
            $display("FAIL %s: got ack=%b err=%b flag=%b type=%0d off=%0d,%0d pix_en=%b, need all 0",
                     name, wep_ack, wep_err, is_wep_img_in_pixel, wep_type, wep_hc, wep_vc, wep_pix_en);
        end
    endtask

    task automatic place(input int x, input int y, input int t);
        r_req = 1'b1; r_x = x; r_y = y; r_t = t;
        scan(0, 3, 10, 10, 1, 1);
        fs_step(1'b1, 1'b0);
        exp_active = 1'b1; exp_x = x; exp_y = y; exp_type = t;
        step(5, 490, 1'b0, 1'b0, 1'b0);
        r_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        hc = 10'd0; vc = 10'd0; frame_start = 1'b0; wep_req = 1'b0;
        wep_x = 10'd0; wep_y = 10'd0; wep_type_in = 4'd0; wep_clear = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_zero("reset_state");
        @(negedge CLK);
        RST = 1'b0;

        // idle frame: coarse sweep of the whole raster, nothing shown
        scan(0, 799, 0, 524, 37, 25);
        fs_step(1'b0, 1'b0);

        // basic placement; req stays high one cycle into the ack
        place(100, 50, 1);
        scan(95, 140, 48, 88, 1, 1);
        fs_step(1'b0, 1'b0);

        // invalid type rejected, old sprite kept
        r_req = 1'b1; r_x = 400; r_y = 300; r_t = 3;
        scan(0, 3, 10, 10, 1, 1);
        fs_step(1'b1, 1'b1);
        r_req = 1'b0;
        scan(98, 137, 50, 85, 1, 35);
        scan(395, 440, 300, 300, 5, 1);

        // request mid-frame: shadow holds until the frame boundary
        scan(0, 630, 0, 195, 90, 15);
        r_req = 1'b1; r_x = 300; r_y = 200; r_t = 2;
        scan(290, 340, 200, 240, 5, 5);
        scan(95, 140, 50, 85, 5, 35);
        fs_step(1'b1, 1'b0);
        exp_active = 1'b1; exp_x = 300; exp_y = 200; exp_type = 2;
        step(5, 490, 1'b0, 1'b0, 1'b0);
        r_req = 1'b0;
        scan(295, 340, 195, 240, 1, 5);
        scan(95, 140, 50, 85, 5, 35);

        // clipping at the bottom-right corner, blanking stays dark
        place(620, 470, 0);
        scan(610, 660, 465, 490, 1, 1);

        // clear with a pending request on the same frame boundary
        r_clr = 1'b1;
        step(0, 100, 1'b0, 1'b0, 1'b0);
        r_req = 1'b1; r_x = 200; r_y = 100; r_t = 1;
        scan(0, 3, 101, 101, 1, 1);
        fs_step(1'b0, 1'b0);
        exp_active = 1'b0;
        r_req = 1'b0;
        scan(195, 240, 95, 140, 5, 5);
        scan(615, 640, 468, 480, 5, 4);
        fs_step(1'b0, 1'b0);

        // reset mid-frame while a sprite is lit and a request is pending
        place(50, 20, 2);
        scan(48, 90, 20, 56, 6, 6);
        r_req = 1'b1; r_x = 500; r_y = 400; r_t = 1;
        step(60, 30, 1'b0, 1'b0, 1'b0);
        drain();
        RST = 1'b1;
        #1;
        check_zero("reset_midframe");
        r_req = 1'b0; wep_req = 1'b0;
        exp_active = 1'b0; prev_flag = 1'b0;
        repeat (2) @(negedge CLK);
        check_zero("reset_held");
        RST = 1'b0;
        fs_step(1'b0, 1'b0);
        scan(495, 540, 395, 440, 5, 5);
        scan(48, 90, 20, 56, 6, 6);
        drain();

        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, need 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
